// File: rtl/psram_bist.sv
// psram_bist: write / read-back self-test engine for the PSRAM controller strobe port.
// Each pass writes a generated pattern over DEPTH words, regenerates the same
// sequence while reading back, counts miscompares and records the first failing
// word. Odd passes use the bitwise complement of the pattern.
module psram_bist #(
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       ADDR_W      = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       DEPTH       = 1024,
  parameter logic [DATA_W-1:0] LFSR_TAPS   = 16'hB400,
  parameter logic [DATA_W-1:0] LFSR_SEED   = 16'hACE1,
  parameter bit                STOP_ON_ERR = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              continuous,
  input  logic              stop,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_strb,
  output logic              mem_wr_strb,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pass_cnt,
  output logic [15:0]       err_cnt,
  output logic              fail_valid,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got
);

  localparam int unsigned       IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);
  localparam logic [DATA_W-1:0] CB_EVEN   = {(DATA_W / 2){2'b10}};
  localparam logic [DATA_W-1:0] CB_ODD    = {(DATA_W / 2){2'b01}};

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ISSUE,
    S_WR_GAP,
    S_WR_WAIT,
    S_RD_ISSUE,
    S_RD_GAP,
    S_RD_WAIT,
    S_PASS_END,
    S_FINISH
  } state_t;

  state_t state_q, state_d;

  // Control events decoded from the FSM, consumed by the datapath registers.
  logic start_test;  // latch configuration, clear statistics
  logic pat_init;    // rewind the pattern generator to word 0
  logic pat_step;    // advance the pattern generator to the next word
  logic wr_fire;     // issue a write strobe next cycle
  logic rd_fire;     // issue a read strobe next cycle
  logic rd_check;    // read data is valid this cycle
  logic end_pass;    // a full write+read pass has completed

  // Configuration captured at start.
  logic [1:0]        mode_q;
  logic              cont_q;
  logic              parity_q;

  // Pattern generator state for the current word.
  logic [IDX_W-1:0]  idx_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [DATA_W-1:0] walk_q;
  logic [DATA_W-1:0] lfsr_q;

  logic [DATA_W-1:0] raw_word;
  logic [DATA_W-1:0] exp_word;
  logic              mismatch;

  // Status outputs decode straight from the state register.
  assign busy = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done = (state_q == S_FINISH);

  // Pattern word for the current index, before the pass-parity inversion.
  always_comb begin
    raw_word = '0;
    unique case (mode_q)
      2'd0:    raw_word = DATA_W'(cur_addr_q);
      2'd1:    raw_word = walk_q;
      2'd2:    raw_word = lfsr_q;
      default: raw_word = idx_q[0] ? CB_ODD : CB_EVEN;
    endcase
  end

  assign exp_word = parity_q ? ~raw_word : raw_word;
  assign mismatch = (mem_rdata != exp_word);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and control-event decode.
  always_comb begin
    // NOTE: every output of this block is defaulted first, so no path leaves a
    // signal unassigned and no latch is inferred.
    state_d    = state_q;
    start_test = 1'b0;
    pat_init   = 1'b0;
    pat_step   = 1'b0;
    wr_fire    = 1'b0;
    rd_fire    = 1'b0;
    rd_check   = 1'b0;
    end_pass   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          start_test = 1'b1;
          pat_init   = 1'b1;
          state_d    = S_WR_ISSUE;
        end
      end
      S_WR_ISSUE: begin
        if (mem_ready) begin
          wr_fire = 1'b1;
          state_d = S_WR_GAP;
        end
      end
      // The controller may still show ready while it registers the strobe.
      S_WR_GAP: state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (mem_ready) begin
          if (idx_q == LAST_IDX) begin
            pat_init = 1'b1;
            state_d  = S_RD_ISSUE;
          end else begin
            pat_step = 1'b1;
            state_d  = S_WR_ISSUE;
          end
        end
      end
      S_RD_ISSUE: begin
        if (mem_ready) begin
          rd_fire = 1'b1;
          state_d = S_RD_GAP;
        end
      end
      S_RD_GAP: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (mem_ready) begin
          rd_check = 1'b1;
          if (STOP_ON_ERR && mismatch) begin
            state_d = S_FINISH;
          end else if (idx_q == LAST_IDX) begin
            state_d = S_PASS_END;
          end else begin
            pat_step = 1'b1;
            state_d  = S_RD_ISSUE;
          end
        end
      end
      S_PASS_END: begin
        end_pass = 1'b1;
        if (cont_q && !stop) begin
          pat_init = 1'b1;
          state_d  = S_WR_ISSUE;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Request port: one-cycle strobes with address/data held until the next issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wr_strb <= 1'b0;
      mem_rd_strb <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      mem_wr_strb <= wr_fire;
      mem_rd_strb <= rd_fire;
      if (wr_fire || rd_fire) mem_addr  <= cur_addr_q;
      if (wr_fire)            mem_wdata <= exp_word;
    end
  end

  // Pattern generator: rewound for the read phase so nothing is stored per word.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      cur_addr_q <= '0;
      walk_q     <= '0;
      lfsr_q     <= '0;
    end else if (pat_init) begin
      idx_q      <= '0;
      cur_addr_q <= BASE_ADDR;
      walk_q     <= DATA_W'(1);
      lfsr_q     <= LFSR_SEED;
    end else if (pat_step) begin
      idx_q      <= idx_q + 1'b1;
      cur_addr_q <= cur_addr_q + ADDR_STEP;
      walk_q     <= {walk_q[DATA_W-2:0], walk_q[DATA_W-1]};
      lfsr_q     <= {1'b0, lfsr_q[DATA_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    end
  end

  // Configuration, pass parity, counters and first-fail capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= '0;
      cont_q     <= 1'b0;
      parity_q   <= 1'b0;
      pass_cnt   <= '0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_addr  <= '0;
      fail_exp   <= '0;
      fail_got   <= '0;
    end else if (start_test) begin
      mode_q     <= mode;
      cont_q     <= continuous;
      parity_q   <= 1'b0;
      pass_cnt   <= '0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_addr  <= '0;
      fail_exp   <= '0;
      fail_got   <= '0;
    end else begin
      if (end_pass) begin
        pass_cnt <= pass_cnt + 16'd1;
        parity_q <= ~parity_q;
      end
      if (rd_check && mismatch) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        if (!fail_valid) begin
          fail_valid <= 1'b1;
          fail_addr  <= mem_addr;
          fail_exp   <= exp_word;
          fail_got   <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_psram_bist.sv
// tb_psram_bist: scoreboard bench for psram_bist with DEPTH=4.
// Stimulus pushes hand-computed write beats and end-of-test status into queues;
// a negedge monitor pops and compares whenever the DUT strobes a write or pulses
// done. A second instance with STOP_ON_ERR=1 faces a responder that always
// returns wrong data.
module tb_psram_bist;

  typedef struct {
    logic [23:0] a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ec;
    logic        fv;
    logic [23:0] fa;
    logic [15:0] fe;
    logic [15:0] fg;
  } done_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start2;
  logic [1:0]  mode;
  logic        continuous, stop;

  // Main instance signals.
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic [23:0] mem_addr;
  logic        mem_rd_strb, mem_wr_strb;
  logic [15:0] mem_wdata;
  logic        busy, done;
  logic [15:0] pass_cnt, err_cnt;
  logic        fail_valid;
  logic [23:0] fail_addr;
  logic [15:0] fail_exp, fail_got;

  // Stop-on-error instance signals.
  logic        mem_ready_2;
  logic [15:0] mem_rdata_2;
  logic [23:0] mem_addr_2;
  logic        mem_rd_strb_2, mem_wr_strb_2;
  logic [15:0] mem_wdata_2;
  logic        busy_2, done_2;
  logic [15:0] pass_cnt_2, err_cnt_2;
  logic        fail_valid_2;
  logic [23:0] fail_addr_2;
  logic [15:0] fail_exp_2, fail_got_2;

  int total = 0;
  int bad   = 0;

  wr_t   wr_q[$];
  done_t done_q[$];
  done_t done2_q[$];

  // Memory model state.
  logic [15:0] mem [0:63];
  int          busy_cnt  = 0;
  int          busy_cnt2 = 0;
  bit          stuck_bit3 = 1'b0;
  int          rd2_cnt = 0;

  always #5 clk = ~clk;

  psram_bist #(
    .DATA_W(16), .ADDR_W(24), .BASE_ADDR(24'd0), .DEPTH(4),
    .LFSR_TAPS(16'hB400), .LFSR_SEED(16'hACE1), .STOP_ON_ERR(1'b0)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .continuous(continuous),
    .stop(stop), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_rd_strb(mem_rd_strb), .mem_wr_strb(mem_wr_strb),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .pass_cnt(pass_cnt),
    .err_cnt(err_cnt), .fail_valid(fail_valid), .fail_addr(fail_addr),
    .fail_exp(fail_exp), .fail_got(fail_got)
  );

  psram_bist #(
    .DATA_W(16), .ADDR_W(24), .BASE_ADDR(24'd0), .DEPTH(4),
    .LFSR_TAPS(16'hB400), .LFSR_SEED(16'hACE1), .STOP_ON_ERR(1'b1)
  ) u_soe (
    .clk(clk), .rst(rst), .start(start2), .mode(mode), .continuous(continuous),
    .stop(stop), .mem_ready(mem_ready_2), .mem_rdata(mem_rdata_2),
    .mem_addr(mem_addr_2), .mem_rd_strb(mem_rd_strb_2), .mem_wr_strb(mem_wr_strb_2),
    .mem_wdata(mem_wdata_2), .busy(busy_2), .done(done_2), .pass_cnt(pass_cnt_2),
    .err_cnt(err_cnt_2), .fail_valid(fail_valid_2), .fail_addr(fail_addr_2),
    .fail_exp(fail_exp_2), .fail_got(fail_got_2)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic note_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got=unexpected event expected=none", name);
  endtask

  function automatic done_t mk_done(input logic [15:0] pc, input logic [15:0] ec,
                                    input logic fv, input logic [23:0] fa,
                                    input logic [15:0] fe, input logic [15:0] fg);
    done_t r;
    r.pc = pc; r.ec = ec; r.fv = fv; r.fa = fa; r.fe = fe; r.fg = fg;
    return r;
  endfunction

  task automatic push_wr(input logic [23:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    wr_q.push_back(e);
  endtask

  task automatic push_words(input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3);
    push_wr(24'd0, w0);
    push_wr(24'd2, w1);
    push_wr(24'd4, w2);
    push_wr(24'd6, w3);
  endtask

  task automatic pulse(input bit second);
    @(negedge clk);
    if (second) start2 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit second);
    bit seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      seen = second ? done_2 : done;
    end
    check(second ? "done2_seen" : "done_seen", {31'd0, seen}, 32'd1);
  endtask

  // Monitor (scoreboard pops) followed by the two memory responders.
  always @(negedge clk) begin
    if (mem_wr_strb || mem_rd_strb)
      check("strobe_excl", {31'd0, mem_wr_strb & mem_rd_strb}, 32'd0);
    if (mem_wr_strb) begin : pop_wr
      wr_t e;
      if (wr_q.size() == 0) begin
        note_fail("wr_extra");
      end else begin
        e = wr_q.pop_front();
        check("wr_addr", {8'd0, mem_addr}, {8'd0, e.a});
        check("wr_data", {16'd0, mem_wdata}, {16'd0, e.d});
      end
    end
    if (done) begin : pop_done
      done_t e;
      if (done_q.size() == 0) begin
        note_fail("done_extra");
      end else begin
        e = done_q.pop_front();
        check("pass_cnt",   {16'd0, pass_cnt},   {16'd0, e.pc});
        check("err_cnt",    {16'd0, err_cnt},    {16'd0, e.ec});
        check("fail_valid", {31'd0, fail_valid}, {31'd0, e.fv});
        check("fail_addr",  {8'd0, fail_addr},   {8'd0, e.fa});
        check("fail_exp",   {16'd0, fail_exp},   {16'd0, e.fe});
        check("fail_got",   {16'd0, fail_got},   {16'd0, e.fg});
      end
    end
    if (start2) rd2_cnt = 0;
    if (mem_rd_strb_2) rd2_cnt++;
    if (done_2) begin : pop_done2
      done_t e;
      if (done2_q.size() == 0) begin
        note_fail("done2_extra");
      end else begin
        e = done2_q.pop_front();
        check("soe_pass_cnt",   {16'd0, pass_cnt_2},   {16'd0, e.pc});
        check("soe_err_cnt",    {16'd0, err_cnt_2},    {16'd0, e.ec});
        check("soe_fail_valid", {31'd0, fail_valid_2}, {31'd0, e.fv});
        check("soe_fail_addr",  {8'd0, fail_addr_2},   {8'd0, e.fa});
        check("soe_fail_exp",   {16'd0, fail_exp_2},   {16'd0, e.fe});
        check("soe_fail_got",   {16'd0, fail_got_2},   {16'd0, e.fg});
        check("soe_reads", rd2_cnt, 32'd1);
      end
    end

    // Ideal memory: drops ready on a strobe, answers two cycles later.
    if (rst) begin
      mem_ready = 1'b1;
      busy_cnt  = 0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) mem_ready = 1'b1;
    end else if (mem_wr_strb) begin
      mem[mem_addr[6:1]] = mem_wdata;
      mem_ready = 1'b0;
      busy_cnt  = 2;
    end else if (mem_rd_strb) begin
      mem_rdata = mem[mem_addr[6:1]] & (stuck_bit3 ? 16'hFFF7 : 16'hFFFF);
      mem_ready = 1'b0;
      busy_cnt  = 2;
    end

    // Faulty responder for the stop-on-error instance: every read returns 0xDEAD.
    if (rst) begin
      mem_ready_2 = 1'b1;
      busy_cnt2   = 0;
    end else if (busy_cnt2 > 0) begin
      busy_cnt2--;
      if (busy_cnt2 == 0) mem_ready_2 = 1'b1;
    end else if (mem_wr_strb_2 || mem_rd_strb_2) begin
      mem_rdata_2 = 16'hDEAD;
      mem_ready_2 = 1'b0;
      busy_cnt2   = 2;
    end
  end

  initial begin
    bit hit;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; mode = 2'd0;
    continuous = 1'b0; stop = 1'b0;
    mem_ready = 1'b1; mem_rdata = '0; mem_ready_2 = 1'b1; mem_rdata_2 = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_wr_strb", {31'd0, mem_wr_strb}, 32'd0);
    check("rst_rd_strb", {31'd0, mem_rd_strb}, 32'd0);
    check("rst_busy",    {31'd0, busy},        32'd0);
    check("rst_done",    {31'd0, done},        32'd0);
    check("rst_pass",    {16'd0, pass_cnt},    32'd0);
    check("rst_err",     {16'd0, err_cnt},     32'd0);
    check("rst_fv",      {31'd0, fail_valid},  32'd0);
    check("rst_addr",    {8'd0, mem_addr},     32'd0);
    check("rst_soe_busy", {31'd0, busy_2},     32'd0);
    rst = 1'b0;

    // 1: address pattern.
    mode = 2'd0;
    push_words(16'h0000, 16'h0002, 16'h0004, 16'h0006);
    done_q.push_back(mk_done(16'd1, 16'd0, 1'b0, 24'd0, 16'h0000, 16'h0000));
    pulse(1'b0);
    wait_done(500, 1'b0);

    // 2: walking ones against a memory with bit 3 stuck low.
    mode = 2'd1;
    stuck_bit3 = 1'b1;
    push_words(16'h0001, 16'h0002, 16'h0004, 16'h0008);
    done_q.push_back(mk_done(16'd1, 16'd1, 1'b1, 24'd6, 16'h0008, 16'h0000));
    pulse(1'b0);
    wait_done(500, 1'b0);
    stuck_bit3 = 1'b0;

    // 3: LFSR sequence from seed 0xACE1.
    mode = 2'd2;
    push_words(16'hACE1, 16'hE270, 16'h7138, 16'h389C);
    done_q.push_back(mk_done(16'd1, 16'd0, 1'b0, 24'd0, 16'h0000, 16'h0000));
    pulse(1'b0);
    wait_done(500, 1'b0);

    // 4: checkerboard soak, stop raised during pass 2 (complemented pass).
    mode = 2'd3;
    continuous = 1'b1;
    push_words(16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555);
    push_words(16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA);
    done_q.push_back(mk_done(16'd2, 16'd0, 1'b0, 24'd0, 16'h0000, 16'h0000));
    pulse(1'b0);
    hit = 1'b0;
    for (int c = 0; c < 500 && !hit; c++) begin
      @(negedge clk);
      hit = (pass_cnt == 16'd1);
    end
    check("pass1_seen", {31'd0, hit}, 32'd1);
    stop = 1'b1;
    wait_done(500, 1'b0);
    stop = 1'b0;
    continuous = 1'b0;

    // 5: stop-on-error instance, every read miscompares.
    mode = 2'd0;
    done2_q.push_back(mk_done(16'd0, 16'd1, 1'b1, 24'd0, 16'h0000, 16'hDEAD));
    pulse(1'b1);
    wait_done(500, 1'b1);

    // 6: reset during WR_WAIT, restart, then a start pulse while busy.
    mode = 2'd0;
    push_words(16'h0000, 16'h0002, 16'h0004, 16'h0006);
    pulse(1'b0);
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      hit = mem_wr_strb;
    end
    check("first_wr_seen", {31'd0, hit}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_wr_strb", {31'd0, mem_wr_strb}, 32'd0);
    check("mid_rst_rd_strb", {31'd0, mem_rd_strb}, 32'd0);
    check("mid_rst_busy",    {31'd0, busy},        32'd0);
    check("mid_rst_addr",    {8'd0, mem_addr},     32'd0);
    check("mid_rst_wdata",   {16'd0, mem_wdata},   32'd0);
    rst = 1'b0;
    wr_q.delete();
    push_words(16'h0000, 16'h0002, 16'h0004, 16'h0006);
    done_q.push_back(mk_done(16'd1, 16'd0, 1'b0, 24'd0, 16'h0000, 16'h0000));
    pulse(1'b0);
    repeat (6) @(negedge clk);
    check("busy_mid_test", {31'd0, busy}, 32'd1);
    mode = 2'd1;
    pulse(1'b0);
    mode = 2'd0;
    wait_done(500, 1'b0);

    repeat (3) @(negedge clk);
    check("wr_q_drained",    wr_q.size(),    32'd0);
    check("done_q_drained",  done_q.size(),  32'd0);
    check("done2_q_drained", done2_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
